// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared types and constants for the AES-128 inverse byte-substitution engine.
// Holds the State/Word types, FSM encoding, the inverse S-box table and the
// legality check for the lane-count parameter.
package inv_sub_bytes_iter_pkg;

  typedef logic [7:0]       byte_t;
  typedef logic [31:0]      word_t;
  // Word w of a state sits at bits [32*w +: 32].
  typedef word_t [3:0]      state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_e;

  localparam int WORDS = 4;

  // AES inverse S-box, indexed by the substituted byte value.
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Lane counts must divide the four state words evenly.
  function automatic bit lanes_legal(input int lanes);
    return (lanes == 1) || (lanes == 2) || (lanes == 4);
  endfunction

endpackage

// File: rtl/inv_sub_word.sv
// Inverse S-box substitution of one 32-bit word (four independent byte lookups).
// Latency: purely combinational.
// Backpressure: none; output follows input.
module inv_sub_word
  import inv_sub_bytes_iter_pkg::*;
(
  input  word_t i_word,
  output word_t o_word
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[8*b +: 8] = INV_SBOX[i_word[8*b +: 8]];
  end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes LANES words per cycle in place in a state register.
// Latency: accept edge, then 4/LANES BUSY cycles, then DONE holds the result.
// Backpressure: one state in flight; input ready only in IDLE, DONE stalls until OutReady_SI.
module inv_sub_bytes_iter
  import inv_sub_bytes_iter_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic   Clk_CI,
  input  logic   Rst_RI,
  input  state_t In_DI,
  input  logic   InValid_SI,
  output logic   InReady_SO,
  output state_t Out_DO,
  output logic   OutValid_SO,
  input  logic   OutReady_SI,
  output logic   Busy_SO
);

  localparam int N  = WORDS / LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (!lanes_legal(LANES)) begin : g_bad_lanes
      $error("inv_sub_bytes_iter: LANES must be 1, 2 or 4");
    end
  endgenerate

  fsm_e            r_fsm;
  fsm_e            w_fsm_nxt;
  logic [CW-1:0]   r_cnt;
  state_t          r_state;

  logic [1:0]      w_base;
  logic            w_last;
  logic            w_accept;
  logic [1:0]      w_idx [LANES];
  word_t           w_sub [LANES];

  // First word handled this cycle; lanes cover consecutive words from here.
  assign w_base   = 2'(r_cnt * LANES);
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = (r_fsm == ST_IDLE) && InValid_SI;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_idx[g] = w_base + 2'(g);
    inv_sub_word u_inv_sub_word (
      .i_word (r_state[w_idx[g]]),
      .o_word (w_sub[g])
    );
  end

  // FSM state register.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) r_fsm <= ST_IDLE;
    else        r_fsm <= w_fsm_nxt;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    InReady_SO  = 1'b0;
    OutValid_SO = 1'b0;
    Busy_SO     = 1'b0;
    case (r_fsm)
      ST_IDLE: begin
        InReady_SO = 1'b1;
        if (InValid_SI) w_fsm_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        Busy_SO = 1'b1;
        if (w_last) w_fsm_nxt = ST_DONE;
      end
      ST_DONE: begin
        OutValid_SO = 1'b1;
        if (OutReady_SI) w_fsm_nxt = ST_IDLE;
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Word-group counter: cleared on accept, wraps after the last group.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_fsm == ST_BUSY) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

  // State register: capture on accept, then overwrite the current words in place.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      r_state <= '0;
    end else if (w_accept) begin
      r_state <= In_DI;
    end else if (r_fsm == ST_BUSY) begin
      for (int g = 0; g < LANES; g++) begin
        r_state[w_idx[g]] <= w_sub[g];
      end
    end
  end

  assign Out_DO = r_state;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter with LANES = 1, 2, 4 instances side by side.
// Reference InvSubBytes table is derived from GF(2^8) inversion plus the forward affine map.
module tb_inv_sub_bytes_iter;

  logic         clk;
  logic         rst;
  logic [127:0] in_d   [3];
  logic         in_v   [3];
  logic         in_r   [3];
  logic [127:0] out_d  [3];
  logic         out_v  [3];
  logic         out_r  [3];
  logic         busy   [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] inv_tab [256];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    inv_sub_bytes_iter #(.LANES(1 << k)) u_dut (
      .Clk_CI      (clk),
      .Rst_RI      (rst),
      .In_DI       (in_d[k]),
      .InValid_SI  (in_v[k]),
      .InReady_SO  (in_r[k]),
      .Out_DO      (out_d[k]),
      .OutValid_SO (out_v[k]),
      .OutReady_SI (out_r[k]),
      .Busy_SO     (busy[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  // Build the inverse table by inverting the forward S-box.
  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] xi, s, xb;
      xb = 8'(x);
      xi = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(xb, 8'(y)) == 8'h01) xi = 8'(y);
      s = xi ^ rotl(xi, 1) ^ rotl(xi, 2) ^ rotl(xi, 3) ^ rotl(xi, 4) ^ 8'h63;
      inv_tab[s] = xb;
    end
  endtask

  function automatic logic [127:0] ref_isb(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[s[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance k; called #1 after an edge with the DUT idle.
  task automatic transact(input int k, input string tag, input logic [127:0] din,
                          input int stall);
    int lat;
    int busy_cyc;
    int n_words;
    logic [127:0] exp;
    n_words = 4 >> k;
    exp = ref_isb(din);
    in_d[k]  = din;
    in_v[k]  = 1'b1;
    out_r[k] = (stall == 0);
    tick();
    in_v[k] = 1'b0;
    in_d[k] = rand128();
    lat = 1;
    busy_cyc = 0;
    while (!out_v[k] && lat < 40) begin
      if (busy[k]) busy_cyc++;
      tick();
      lat++;
    end
    check({tag, " valid"}, 128'(out_v[k]), 128'd1);
    check({tag, " latency"}, 128'(lat), 128'(n_words + 1));
    check({tag, " busy cycles"}, 128'(busy_cyc), 128'(n_words));
    check({tag, " data"}, out_d[k], exp);
    for (int i = 0; i < stall; i++) begin
      if (i == 3) begin
        in_v[k] = 1'b1;
        in_d[k] = rand128();
      end
      if (i == 5) in_v[k] = 1'b0;
      tick();
      check({tag, " stall data"}, out_d[k], exp);
      check({tag, " stall ready"}, 128'(in_r[k]), 128'd0);
      check({tag, " stall valid"}, 128'(out_v[k]), 128'd1);
    end
    in_v[k]  = 1'b0;
    out_r[k] = 1'b1;
    tick();
    check({tag, " handoff valid"}, 128'(out_v[k]), 128'd0);
    check({tag, " handoff ready"}, 128'(in_r[k]), 128'd1);
    out_r[k] = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_d[k] = '0; in_v[k] = 1'b0; out_r[k] = 1'b0;
    end
    build_model();

    // Asynchronous reset between edges.
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("reset in_ready", 128'(in_r[k]), 128'd1);
      check("reset out_valid", 128'(out_v[k]), 128'd0);
      check("reset busy", 128'(busy[k]), 128'd0);
      check("reset out_data", out_d[k], 128'd0);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();

    transact(0, "l1 all63", {16{8'h63}}, 0);
    transact(0, "l1 bytemap", {4{32'h7C0016ED}}, 0);
    check("l1 bytemap ref", ref_isb({4{32'h7C0016ED}}), {4{32'h0152FF53}});
    transact(0, "l1 backpressure", rand128(), 10);
    transact(0, "l1 after stall", rand128(), 0);

    // Reset during the second BUSY cycle discards the state.
    in_d[0] = rand128();
    in_v[0] = 1'b1;
    out_r[0] = 1'b1;
    tick();
    in_v[0] = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("midreset valid", 128'(out_v[0]), 128'd0);
    check("midreset ready", 128'(in_r[0]), 128'd1);
    check("midreset data", out_d[0], 128'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_v[0]) seen++;
      tick();
    end
    check("midreset no output", 128'(seen), 128'd0);
    out_r[0] = 1'b0;
    transact(0, "l1 post reset", {16{8'h63}}, 0);

    transact(1, "l2 all16", {16{8'h16}}, 0);
    transact(2, "l4 all16", {16{8'h16}}, 0);

    for (int k = 0; k < 3; k++)
      for (int t = 0; t < 15; t++)
        transact(k, $sformatf("rand l%0d #%0d", 1 << k, t), rand128(), $urandom_range(0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
